// File: rtl/can_command_decoder_if.sv
// Receive-frame and acknowledge channels between the CAN controller and can_command_decoder.
// master = CAN controller side, slave = decoder side.
interface can_command_decoder_if;
  logic        rx_frame_valid;
  logic        rx_frame_ready;
  logic [10:0] rx_frame_id;
  logic [3:0]  rx_frame_dlc;
  logic [63:0] rx_frame_data;
  logic        tx_ack_valid;
  logic        tx_ack_ready;
  logic [7:0]  tx_ack_status;
  logic [7:0]  tx_ack_seq;

  modport master (
    output rx_frame_valid, rx_frame_id, rx_frame_dlc, rx_frame_data, tx_ack_ready,
    input  rx_frame_ready, tx_ack_valid, tx_ack_status, tx_ack_seq
  );

  modport slave (
    input  rx_frame_valid, rx_frame_id, rx_frame_dlc, rx_frame_data, tx_ack_ready,
    output rx_frame_ready, tx_ack_valid, tx_ack_status, tx_ack_seq
  );
endinterface

// File: rtl/can_command_decoder.sv
// Validates CAN motor command frames, drives the registered mode outputs and acknowledges each
// frame. Define CAN_CMD_WATCHDOG_EN to add the command-silence watchdog.
module can_command_decoder #(
  parameter logic [10:0]  CMD_FRAME_ID       = 11'h120,
  parameter int unsigned  CMD_TIMEOUT_CYCLES = 32'd5_000_000,
  parameter int unsigned  DATA_WIDTH         = 16,
  parameter logic [DATA_WIDTH/2-1:0] MOTOR_START_CMD     = 'h01,
  parameter logic [DATA_WIDTH/2-1:0] MOTOR_STOP_CMD      = 'h00,
  parameter logic [DATA_WIDTH/2-1:0] BAND_BREAK_CLOSE    = 'h01,
  parameter logic [DATA_WIDTH/2-1:0] BAND_BREAK_OPEN     = 'h02,
  parameter logic [DATA_WIDTH/4-1:0] MOTOR_SPEED_MODE    = 'h1,
  parameter logic [DATA_WIDTH/4-1:0] MOTOR_LOCATION_MODE = 'h2
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      system_initilization_done_in,
  can_command_decoder_if.slave      can_bus,
  output logic [DATA_WIDTH/2-1:0]   band_breaks_mode_out,
  output logic [DATA_WIDTH/2-1:0]   pmsm_start_stop_mode_out,
  output logic [DATA_WIDTH/4-1:0]   pmsm_work_mode_out,
  output logic                      cmd_timeout_fault_out
);

  localparam int unsigned CmdW  = DATA_WIDTH / 2;
  localparam int unsigned ModeW = DATA_WIDTH / 4;

  localparam logic [7:0] StatusOk       = 8'h00;
  localparam logic [7:0] StatusBadDlc   = 8'h02;
  localparam logic [7:0] StatusBadSum   = 8'h03;
  localparam logic [7:0] StatusBadField = 8'h04;
  localparam logic [7:0] StatusNoInit   = 8'h05;
  localparam logic [7:0] StatusModeBusy = 8'h06;
  localparam logic [7:0] StatusDupSeq   = 8'h07;

  typedef enum logic [1:0] {StIdle, StCheck, StApply, StAck} state_e;

  state_e      state_q;
  logic [3:0]  frame_dlc_q;
  logic [63:0] frame_data_q;
  logic [7:0]  status_q;
  logic [7:0]  last_seq_q;
  logic        last_seq_valid_q;

  logic [CmdW-1:0]  f_start_stop;
  logic [CmdW-1:0]  f_band_brake;
  logic [ModeW-1:0] f_work_mode;
  logic [7:0]       f_seq;
  logic [7:0]       f_sum;
  logic             f_legal;
  logic [7:0]       status_d;

  assign f_start_stop = CmdW'(frame_data_q[7:0]);
  assign f_band_brake = CmdW'(frame_data_q[15:8]);
  assign f_work_mode  = ModeW'(frame_data_q[19:16]);
  assign f_seq        = frame_data_q[31:24];
  assign f_sum        = frame_data_q[7:0] ^ frame_data_q[15:8] ^ frame_data_q[23:16]
                      ^ frame_data_q[31:24] ^ frame_data_q[39:32] ^ frame_data_q[47:40]
                      ^ frame_data_q[55:48];

  assign f_legal = ((f_start_stop == MOTOR_START_CMD) || (f_start_stop == MOTOR_STOP_CMD))
                && ((f_band_brake == BAND_BREAK_CLOSE) || (f_band_brake == BAND_BREAK_OPEN))
                && ((f_work_mode == MOTOR_SPEED_MODE) || (f_work_mode == MOTOR_LOCATION_MODE));

  // First failing check wins.
  always_comb begin
    status_d = StatusOk;
    if (frame_dlc_q != 4'd8) begin
      status_d = StatusBadDlc;
    end else if (frame_data_q[63:56] != f_sum) begin
      status_d = StatusBadSum;
    end else if (!f_legal) begin
      status_d = StatusBadField;
    end else if (!system_initilization_done_in) begin
      status_d = StatusNoInit;
    end else if ((f_work_mode != pmsm_work_mode_out)
              && (pmsm_start_stop_mode_out == MOTOR_START_CMD)
              && (f_start_stop != MOTOR_STOP_CMD)) begin
      status_d = StatusModeBusy;
    end else if (last_seq_valid_q && (f_seq == last_seq_q)) begin
      status_d = StatusDupSeq;
    end
  end

`ifdef CAN_CMD_WATCHDOG_EN
  localparam logic [31:0] TimeoutLast = 32'(CMD_TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt_q;
`else
  assign cmd_timeout_fault_out = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q                  <= StIdle;
      frame_dlc_q              <= '0;
      frame_data_q             <= '0;
      status_q                 <= '0;
      last_seq_q               <= '0;
      last_seq_valid_q         <= 1'b0;
      can_bus.rx_frame_ready   <= 1'b1;
      can_bus.tx_ack_valid     <= 1'b0;
      can_bus.tx_ack_status    <= '0;
      can_bus.tx_ack_seq       <= '0;
      band_breaks_mode_out     <= '0;
      pmsm_start_stop_mode_out <= '0;
      pmsm_work_mode_out       <= '0;
`ifdef CAN_CMD_WATCHDOG_EN
      wd_cnt_q                 <= '0;
      cmd_timeout_fault_out    <= 1'b0;
`endif
    end else begin
`ifdef CAN_CMD_WATCHDOG_EN
      if (pmsm_start_stop_mode_out == MOTOR_START_CMD) begin
        if (wd_cnt_q == TimeoutLast) begin
          pmsm_start_stop_mode_out <= MOTOR_STOP_CMD;
          cmd_timeout_fault_out    <= 1'b1;
          wd_cnt_q                 <= '0;
        end else begin
          wd_cnt_q <= wd_cnt_q + 32'd1;
        end
      end else begin
        wd_cnt_q <= '0;
      end
`endif
      // An OK frame in APPLY is assigned below, so it overrides a coincident timeout.
      unique case (state_q)
        StIdle: begin
          if (can_bus.rx_frame_valid && can_bus.rx_frame_ready
              && (can_bus.rx_frame_id == CMD_FRAME_ID)) begin
            frame_dlc_q            <= can_bus.rx_frame_dlc;
            frame_data_q           <= can_bus.rx_frame_data;
            can_bus.rx_frame_ready <= 1'b0;
            state_q                <= StCheck;
          end
        end
        StCheck: begin
          status_q <= status_d;
          state_q  <= StApply;
        end
        StApply: begin
          can_bus.tx_ack_valid  <= 1'b1;
          can_bus.tx_ack_status <= status_q;
          can_bus.tx_ack_seq    <= f_seq;
          if (status_q == StatusOk) begin
            pmsm_start_stop_mode_out <= f_start_stop;
            band_breaks_mode_out     <= f_band_brake;
            pmsm_work_mode_out       <= f_work_mode;
            last_seq_q               <= f_seq;
            last_seq_valid_q         <= 1'b1;
`ifdef CAN_CMD_WATCHDOG_EN
            wd_cnt_q                 <= '0;
            cmd_timeout_fault_out    <= 1'b0;
`endif
          end
          state_q <= StAck;
        end
        StAck: begin
          if (can_bus.tx_ack_ready) begin
            can_bus.tx_ack_valid   <= 1'b0;
            can_bus.rx_frame_ready <= 1'b1;
            state_q                <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_can_command_decoder.sv
// Directed self-checking bench for can_command_decoder; watchdog cases run when
// CAN_CMD_WATCHDOG_EN is defined.
module tb_can_command_decoder;

  localparam logic [7:0] Start = 8'h01;
  localparam logic [7:0] Stop  = 8'h00;
  localparam logic [7:0] Close = 8'h01;
  localparam logic [7:0] Open  = 8'h02;
  localparam logic [7:0] Speed = 8'h01;
  localparam logic [7:0] Loc   = 8'h02;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_done = 1'b0;
  logic [7:0] band_breaks_mode;
  logic [7:0] start_stop_mode;
  logic [3:0] work_mode;
  logic       timeout_fault;

  int n_total = 0;
  int n_bad   = 0;

  can_command_decoder_if bus ();

  can_command_decoder #(
    .CMD_TIMEOUT_CYCLES (100)
  ) dut (
    .sys_clk                      (sys_clk),
    .reset_n                      (reset_n),
    .system_initilization_done_in (init_done),
    .can_bus                      (bus),
    .band_breaks_mode_out         (band_breaks_mode),
    .pmsm_start_stop_mode_out     (start_stop_mode),
    .pmsm_work_mode_out           (work_mode),
    .cmd_timeout_fault_out        (timeout_fault)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] sq);
    logic [7:0] sum;
    sum = b0 ^ b1 ^ b2 ^ sq ^ 8'h11 ^ 8'h22 ^ 8'h33;
    return {sum, 8'h33, 8'h22, 8'h11, sq, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] ss, input logic [7:0] bb,
                           input logic [7:0] wm);
    check_eq({tag, "_ss"}, start_stop_mode, ss);
    check_eq({tag, "_bb"}, band_breaks_mode, bb);
    check_eq({tag, "_wm"}, work_mode, wm[3:0]);
  endtask

  // Full handshake of one matching-ID frame; acknowledge held for 'hold' extra cycles.
  task automatic send(input string tag, input logic [3:0] dlc, input logic [63:0] data,
                      input logic [7:0] exp_st, input int hold);
    check_eq({tag, "_rdy"}, bus.rx_frame_ready, 1);
    bus.rx_frame_valid = 1'b1;
    bus.rx_frame_id    = 11'h120;
    bus.rx_frame_dlc   = dlc;
    bus.rx_frame_data  = data;
    tick();
    bus.rx_frame_valid = 1'b0;
    check_eq({tag, "_busy"}, bus.rx_frame_ready, 0);
    tick();
    check_eq({tag, "_early"}, bus.tx_ack_valid, 0);
    tick();
    check_eq({tag, "_ackv"}, bus.tx_ack_valid, 1);
    check_eq({tag, "_st"}, bus.tx_ack_status, exp_st);
    check_eq({tag, "_seq"}, bus.tx_ack_seq, data[31:24]);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_v"}, bus.tx_ack_valid, 1);
      check_eq({tag, "_hold_st"}, bus.tx_ack_status, exp_st);
      check_eq({tag, "_hold_seq"}, bus.tx_ack_seq, data[31:24]);
      check_eq({tag, "_hold_rdy"}, bus.rx_frame_ready, 0);
    end
    bus.tx_ack_ready = 1'b1;
    tick();
    bus.tx_ack_ready = 1'b0;
    check_eq({tag, "_done_v"}, bus.tx_ack_valid, 0);
    check_eq({tag, "_done_rdy"}, bus.rx_frame_ready, 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_rdy"}, bus.rx_frame_ready, 1);
    check_eq({tag, "_ackv"}, bus.tx_ack_valid, 0);
    check_eq({tag, "_ackst"}, bus.tx_ack_status, 0);
    check_eq({tag, "_ackseq"}, bus.tx_ack_seq, 0);
    check_eq({tag, "_fault"}, timeout_fault, 0);
    check_out(tag, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] bad_sum;
    bus.rx_frame_valid = 1'b0;
    bus.rx_frame_id    = '0;
    bus.rx_frame_dlc   = '0;
    bus.rx_frame_data  = '0;
    bus.tx_ack_ready   = 1'b0;

    repeat (3) tick();
    check_reset("reset");
    reset_n   = 1'b1;
    init_done = 1'b1;
    tick();

    send("legal", 4'd8, mk(Start, Close, Loc, 8'h01), 8'h00, 5);
    check_out("legal", Start, Close, Loc);

    bad_sum = mk(Start, Open, Loc, 8'h02) ^ {8'h01, 56'h0};
    send("csum", 4'd8, bad_sum, 8'h03, 0);
    check_out("csum", Start, Close, Loc);
    send("dlc", 4'd6, bad_sum, 8'h02, 0);
    check_out("dlc", Start, Close, Loc);
    send("field", 4'd8, mk(Start, 8'hAA, Loc, 8'h04), 8'h04, 0);
    check_out("field", Start, Close, Loc);
    init_done = 1'b0;
    send("noinit", 4'd8, mk(Start, Open, Loc, 8'h05), 8'h05, 0);
    init_done = 1'b1;
    check_out("noinit", Start, Close, Loc);
    send("dup", 4'd8, mk(Start, Open, Loc, 8'h01), 8'h07, 0);
    check_out("dup", Start, Close, Loc);

    send("busy", 4'd8, mk(Start, Close, Speed, 8'h10), 8'h06, 0);
    check_out("busy", Start, Close, Loc);
    send("stop", 4'd8, mk(Stop, Open, Loc, 8'h02), 8'h00, 0);
    check_out("stop", Stop, Open, Loc);
    send("speed", 4'd8, mk(Start, Close, Speed, 8'h03), 8'h00, 0);
    check_out("speed", Start, Close, Speed);

    bus.rx_frame_valid = 1'b1;
    bus.rx_frame_id    = 11'h121;
    bus.rx_frame_dlc   = 4'd8;
    bus.rx_frame_data  = mk(Stop, Open, Loc, 8'h09);
    tick();
    bus.rx_frame_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("foreign_rdy", bus.rx_frame_ready, 1);
      check_eq("foreign_ackv", bus.tx_ack_valid, 0);
      tick();
    end
    check_out("foreign", Start, Close, Speed);

`ifdef CAN_CMD_WATCHDOG_EN
    send("wd_arm", 4'd8, mk(Start, Close, Speed, 8'h04), 8'h00, 0);
    repeat (98) tick();
    check_eq("wd_pre_ss", start_stop_mode, Start);
    check_eq("wd_pre_fault", timeout_fault, 0);
    tick();
    check_eq("wd_fault", timeout_fault, 1);
    check_out("wd_stop", Stop, Close, Speed);
    send("wd_clr", 4'd8, mk(Start, Open, Speed, 8'h05), 8'h00, 0);
    check_eq("wd_clr_fault", timeout_fault, 0);
    check_out("wd_clr", Start, Open, Speed);
    repeat (96) tick();
    send("wd_race", 4'd8, mk(Start, Close, Speed, 8'h06), 8'h00, 0);
    check_eq("wd_race_fault", timeout_fault, 0);
    check_out("wd_race", Start, Close, Speed);
`else
    check_eq("wd_off_fault", timeout_fault, 0);
`endif

    send("pre_rst", 4'd8, mk(Stop, Open, Loc, 8'h01), 8'h00, 0);
    check_out("pre_rst", Stop, Open, Loc);

    bus.rx_frame_valid = 1'b1;
    bus.rx_frame_id    = 11'h120;
    bus.rx_frame_dlc   = 4'd8;
    bus.rx_frame_data  = mk(Start, Close, Loc, 8'h07);
    tick();
    bus.rx_frame_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_reset("midrst");
    repeat (3) tick();
    check_eq("midrst_noack", bus.tx_ack_valid, 0);

    send("post_rst", 4'd8, mk(Start, Close, Loc, 8'h01), 8'h00, 0);
    check_out("post_rst", Start, Close, Loc);

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
